// File: rtl/mul_div_unit_pkg.sv
// Shared ALU operation codes and mul/div FSM encodings.
// Imported by ctrl_unit, the single-cycle ALU and the mul/div unit.
package mul_div_unit_pkg;

  localparam logic [4:0] ALU_ADD    = 5'b00000;
  localparam logic [4:0] ALU_SUB    = 5'b00001;
  localparam logic [4:0] ALU_SLL    = 5'b00010;
  localparam logic [4:0] ALU_SLT    = 5'b00011;
  localparam logic [4:0] ALU_SLTU   = 5'b00100;
  localparam logic [4:0] ALU_XOR    = 5'b00101;
  localparam logic [4:0] ALU_SRL    = 5'b00110;
  localparam logic [4:0] ALU_SRA    = 5'b00111;
  localparam logic [4:0] ALU_OR     = 5'b01000;
  localparam logic [4:0] ALU_AND    = 5'b01001;
  localparam logic [4:0] ALU_LUI    = 5'b01010;
  localparam logic [4:0] ALU_AUIPC  = 5'b01011;

  localparam logic [4:0] ALU_MUL    = 5'b11000;
  localparam logic [4:0] ALU_MULH   = 5'b11001;
  localparam logic [4:0] ALU_MULHSU = 5'b11010;
  localparam logic [4:0] ALU_MULHU  = 5'b11011;
  localparam logic [4:0] ALU_DIV    = 5'b11100;
  localparam logic [4:0] ALU_REM    = 5'b11101;
  localparam logic [4:0] ALU_DIVU   = 5'b11110;
  localparam logic [4:0] ALU_REMU   = 5'b11111;

  localparam logic [4:0] CALC_LAST  = 5'd31;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_FIX,
    ST_DONE
  } md_state_e;

  function automatic logic is_muldiv_op(input logic [4:0] op);
    return op[4:3] == 2'b11;
  endfunction

endpackage

// File: rtl/mul_div_datapath.sv
// Shared shift-add multiplier / restoring divider working on operand magnitudes,
// with sign restoration and divide special-case overrides applied on the result.
module mul_div_datapath
  import mul_div_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            step,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] operand1,
  input  logic [XLEN-1:0] operand2,
  output logic [XLEN-1:0] result
);

  logic [2:0]        op_q, op_d;
  logic              sign1_q, sign1_d;
  logic              sign2_q, sign2_d;
  logic              div_zero_q, div_zero_d;
  logic              ovf_q, ovf_d;
  logic [XLEN-1:0]   addend_q, addend_d;
  logic [2*XLEN-1:0] work_q, work_d;

  logic              signed1, signed2;
  logic [XLEN-1:0]   abs1, abs2;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift;
  logic              div_fits;
  logic [XLEN-1:0]   div_diff;

  // work holds {acc_hi, multiplier} for multiply and {remainder, quotient} for divide
  always_comb begin
    op_d       = op_q;
    sign1_d    = sign1_q;
    sign2_d    = sign2_q;
    div_zero_d = div_zero_q;
    ovf_d      = ovf_q;
    addend_d   = addend_q;
    work_d     = work_q;

    signed1 = (op == ALU_MULH) || (op == ALU_MULHSU) || (op == ALU_DIV) || (op == ALU_REM);
    signed2 = (op == ALU_MULH) || (op == ALU_DIV) || (op == ALU_REM);
    abs1    = (signed1 && operand1[XLEN-1]) ? -operand1 : operand1;
    abs2    = (signed2 && operand2[XLEN-1]) ? -operand2 : operand2;

    mul_sum   = {1'b0, work_q[2*XLEN-1:XLEN]} + {1'b0, (work_q[0] ? addend_q : '0)};
    div_shift = work_q[2*XLEN-1:XLEN-1];
    div_fits  = div_shift >= {1'b0, addend_q};
    div_diff  = div_shift[XLEN-1:0] - addend_q;

    if (load) begin
      op_d       = op[2:0];
      sign1_d    = signed1 && operand1[XLEN-1];
      sign2_d    = signed2 && operand2[XLEN-1];
      div_zero_d = operand2 == '0;
      ovf_d      = signed2 && (operand1 == {1'b1, {(XLEN-1){1'b0}}}) && (operand2 == '1);
      addend_d   = op[2] ? abs2 : abs1;
      work_d     = {{XLEN{1'b0}}, (op[2] ? abs1 : abs2)};
    end else if (step) begin
      if (op_q[2]) begin
        work_d = div_fits ? {div_diff, work_q[XLEN-2:0], 1'b1}
                          : {div_shift[XLEN-1:0], work_q[XLEN-2:0], 1'b0};
      end else begin
        work_d = {mul_sum, work_q[XLEN-1:1]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q       <= '0;
      sign1_q    <= 1'b0;
      sign2_q    <= 1'b0;
      div_zero_q <= 1'b0;
      ovf_q      <= 1'b0;
      addend_q   <= '0;
      work_q     <= '0;
    end else begin
      op_q       <= op_d;
      sign1_q    <= sign1_d;
      sign2_q    <= sign2_d;
      div_zero_q <= div_zero_d;
      ovf_q      <= ovf_d;
      addend_q   <= addend_d;
      work_q     <= work_d;
    end
  end

  logic              sign_diff;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem;

  // Divide-by-zero remainder falls out naturally as the signed dividend
  always_comb begin
    sign_diff = sign1_q ^ sign2_q;
    prod      = sign_diff ? -work_q : work_q;
    quo       = sign_diff ? -work_q[XLEN-1:0] : work_q[XLEN-1:0];
    rem       = sign1_q ? -work_q[2*XLEN-1:XLEN] : work_q[2*XLEN-1:XLEN];
    if (div_zero_q) begin
      quo = '1;
    end
    if (ovf_q) begin
      quo = {1'b1, {(XLEN-1){1'b0}}};
      rem = '0;
    end
    case (op_q)
      3'b000:         result = prod[XLEN-1:0];
      3'b001, 3'b010,
      3'b011:         result = prod[2*XLEN-1:XLEN];
      3'b100, 3'b110: result = quo;
      default:        result = rem;
    endcase
  end

endmodule

// File: rtl/mul_div_unit.sv
// RV32M iterative multiply/divide unit: FSM, iteration counter and start/busy/done
// handshake around the shared datapath; fixed 33-cycle latency for every op.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            START,
  input  logic [4:0]      ALU_OP,
  input  logic [XLEN-1:0] OPERAND1,
  input  logic [XLEN-1:0] OPERAND2,
  output logic            BUSY,
  output logic            DONE,
  output logic [XLEN-1:0] RESULT
);

  md_state_e       state_q, state_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [XLEN-1:0] dp_result;
  logic            accept;

  // The DONE cycle may accept a new op so back-to-back ops run every 34 cycles
  assign accept = START && is_muldiv_op(ALU_OP) &&
                  ((state_q == ST_IDLE) || (state_q == ST_DONE));

  mul_div_datapath #(.XLEN(XLEN)) u_datapath (
    .clk      (CLK),
    .rst      (RESET),
    .load     (accept),
    .step     (state_q == ST_CALC),
    .op       (ALU_OP),
    .operand1 (OPERAND1),
    .operand2 (OPERAND2),
    .result   (dp_result)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (accept) begin
          state_d = ST_CALC;
          cnt_d   = '0;
        end
      end
      ST_CALC: begin
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == CALC_LAST) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        result_d = dp_result;
        state_d  = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign BUSY   = (state_q == ST_CALC) || (state_q == ST_FIX);
  assign DONE   = state_q == ST_DONE;
  assign RESULT = result_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: table-driven vectors scored through a
// result queue, plus handshake, back-to-back and mid-operation reset sequences.
module tb_mul_div_unit;
  import mul_div_unit_pkg::*;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        START;
  logic [4:0]  ALU_OP;
  logic [31:0] OPERAND1;
  logic [31:0] OPERAND2;
  logic        BUSY;
  logic        DONE;
  logic [31:0] RESULT;

  int checks   = 0;
  int failures = 0;
  int cycle    = 0;
  int busyRun  = 0;

  typedef struct {
    string       name;
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] exp;
    int          startCycle;
  } sb_t;

  vec_t vecs[$];
  sb_t  sbQueue[$];

  mul_div_unit #(.XLEN(32)) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .START    (START),
    .ALU_OP   (ALU_OP),
    .OPERAND1 (OPERAND1),
    .OPERAND2 (OPERAND2),
    .BUSY     (BUSY),
    .DONE     (DONE),
    .RESULT   (RESULT)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  // Scoreboard side: every DONE pops one expected result and checks timing
  always @(negedge CLK) begin
    sb_t item;
    if (DONE === 1'b1) begin
      if (sbQueue.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_done: got DONE=1 at cycle %0d expected no DONE", cycle);
      end else begin
        item = sbQueue.pop_front();
        checkOutput({item.name, " result"}, RESULT, item.exp);
        checkOutput({item.name, " latency"}, 32'(cycle - item.startCycle), 32'd33);
        checkOutput({item.name, " busy_cycles"}, 32'(busyRun), 32'd33);
        checkOutput({item.name, " busy_in_done"}, {31'd0, BUSY}, 32'd0);
      end
      busyRun = 0;
    end else if (BUSY === 1'b1) begin
      busyRun++;
    end else begin
      busyRun = 0;
    end
  end

  task automatic addVec(input string name, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    vec_t v;
    v.name = name;
    v.op   = op;
    v.a    = a;
    v.b    = b;
    v.exp  = exp;
    vecs.push_back(v);
  endtask

  // Called at a negedge; drives one START cycle and scrambles inputs afterwards
  task automatic applyStimulus(input string name, input logic [4:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] exp, input bit accept);
    sb_t item;
    START    = 1'b1;
    ALU_OP   = op;
    OPERAND1 = a;
    OPERAND2 = b;
    if (accept) begin
      item.name       = name;
      item.exp        = exp;
      item.startCycle = cycle + 1;
      sbQueue.push_back(item);
    end
    @(posedge CLK);
    @(negedge CLK);
    START    = 1'b0;
    ALU_OP   = 5'($urandom);
    OPERAND1 = $urandom;
    OPERAND2 = $urandom;
    checkOutput({name, " busy_after_start"}, {31'd0, BUSY}, {31'd0, accept});
  endtask

  task automatic waitDone(input int bound);
    int n = 0;
    while (sbQueue.size() != 0 && n < bound) begin
      @(negedge CLK);
      n++;
    end
    if (sbQueue.size() != 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL done_timeout: got %0d results pending expected 0", sbQueue.size());
      sbQueue.delete();
    end
  endtask

  task automatic waitForDoneEdge(input int bound);
    int n = 0;
    while (DONE !== 1'b1 && n < bound) begin
      @(negedge CLK);
      n++;
    end
    checkOutput("done_edge_seen", {31'd0, DONE}, 32'd1);
  endtask

  initial begin
    RESET    = 1'b1;
    START    = 1'b0;
    ALU_OP   = '0;
    OPERAND1 = '0;
    OPERAND2 = '0;
    repeat (3) @(negedge CLK);
    checkOutput("reset BUSY", {31'd0, BUSY}, 32'd0);
    checkOutput("reset DONE", {31'd0, DONE}, 32'd0);
    checkOutput("reset RESULT", RESULT, 32'd0);
    RESET = 1'b0;
    @(negedge CLK);

    addVec("MUL_7xm3",      ALU_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB);
    addVec("MUL_big",       ALU_MUL,    32'h12345678, 32'd9,        32'hA3D70A38);
    addVec("MULH_min_min",  ALU_MULH,   32'h80000000, 32'h80000000, 32'h40000000);
    addVec("MULH_m1_m1",    ALU_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000);
    addVec("MULH_carry",    ALU_MULH,   32'h40000000, 32'd4,        32'h00000001);
    addVec("MULHU_max",     ALU_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
    addVec("MULHSU_max",    ALU_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
    addVec("MULHSU_m2x3",   ALU_MULHSU, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF);
    addVec("MULHSU_2xmax",  ALU_MULHSU, 32'd2,        32'hFFFFFFFF, 32'h00000001);
    addVec("DIV_m7_2",      ALU_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD);
    addVec("REM_m7_2",      ALU_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF);
    addVec("DIV_7_m2",      ALU_DIV,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD);
    addVec("REM_m7_m2",     ALU_REM,    32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF);
    addVec("DIVU_big",      ALU_DIVU,   32'hFFFFFFF9, 32'd2,        32'h7FFFFFFC);
    addVec("REMU_7_2",      ALU_REMU,   32'd7,        32'd2,        32'd1);
    addVec("DIV_5_0",       ALU_DIV,    32'd5,        32'd0,        32'hFFFFFFFF);
    addVec("REM_5_0",       ALU_REM,    32'd5,        32'd0,        32'd5);
    addVec("REM_m5_0",      ALU_REM,    32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB);
    addVec("DIVU_5_0",      ALU_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF);
    addVec("REMU_5_0",      ALU_REMU,   32'd5,        32'd0,        32'd5);
    addVec("DIV_ovf",       ALU_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000);
    addVec("REM_ovf",       ALU_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, 1'b1);
      waitDone(60);
    end

    // A second START five cycles in must not disturb the running divide
    applyStimulus("DIVU_keep", ALU_DIVU, 32'd100, 32'd7, 32'd14, 1'b1);
    repeat (3) @(negedge CLK);
    START    = 1'b1;
    ALU_OP   = ALU_MUL;
    OPERAND1 = 32'd2;
    OPERAND2 = 32'd3;
    @(posedge CLK);
    @(negedge CLK);
    START = 1'b0;
    checkOutput("restart_ignored busy", {31'd0, BUSY}, 32'd1);
    waitDone(60);
    repeat (3) @(negedge CLK);

    // Non mul/div op codes produce no activity at all
    applyStimulus("op_00000", ALU_ADD, 32'd5, 32'd6, 32'd0, 1'b0);
    applyStimulus("op_10111", 5'b10111, 32'd5, 32'd6, 32'd0, 1'b0);
    repeat (40) @(negedge CLK);
    checkOutput("invalid_op busy_late", {31'd0, BUSY}, 32'd0);
    checkOutput("invalid_op done_late", {31'd0, DONE}, 32'd0);

    // Second op accepted on the edge that ends the first op's DONE cycle
    applyStimulus("B2B_first", ALU_MUL, 32'd6, 32'd7, 32'd42, 1'b1);
    waitForDoneEdge(60);
    applyStimulus("B2B_second", ALU_DIVU, 32'd1000, 32'd10, 32'd100, 1'b1);
    waitDone(60);
    repeat (2) @(negedge CLK);

    // Reset ten cycles into a divide aborts it without any DONE
    START    = 1'b1;
    ALU_OP   = ALU_DIV;
    OPERAND1 = 32'd100;
    OPERAND2 = 32'd3;
    @(posedge CLK);
    @(negedge CLK);
    START = 1'b0;
    repeat (8) @(negedge CLK);
    RESET = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    checkOutput("abort BUSY", {31'd0, BUSY}, 32'd0);
    checkOutput("abort DONE", {31'd0, DONE}, 32'd0);
    checkOutput("abort RESULT", RESULT, 32'd0);
    RESET = 1'b0;
    repeat (45) @(negedge CLK);
    applyStimulus("MUL_after_reset", ALU_MUL, 32'd3, 32'd4, 32'd12, 1'b1);
    waitDone(60);
    repeat (3) @(negedge CLK);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
